// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU address path.
// It captures one request, waits a fixed number of cycles, then performs the
// access and pulses ready. Misaligned and out-of-range requests skip the
// storage array and return a one-cycle error response instead.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign,
  output logic        oob
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [1:0]  size_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [4:0]    byte_sh;
  logic [4:0]    half_sh;
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic [31:0]   rd_ext;
  logic          mem_we;

  // Byte never misaligns; halfword needs addr[0]=0; word and reserved need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b10:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  // The word index must fall inside the storage array.
  function automatic logic is_oob(input logic [29:0] word_idx);
    return word_idx >= 30'(DEPTH);
  endfunction

  assign idx     = addr_q[AW+1:2];
  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};

  // Lane merge for writes and zero-extended lane extraction for reads.
  always_comb begin
    cur_word = mem[idx];
    merged   = cur_word;
    rd_ext   = cur_word;
    case (size_q)
      2'b10: begin
        merged[byte_sh +: 8] = wdata_q[7:0];
        rd_ext = {24'h0, cur_word[byte_sh +: 8]};
      end
      2'b01: begin
        merged[half_sh +: 16] = wdata_q[15:0];
        rd_ext = {16'h0, cur_word[half_sh +: 16]};
      end
      default: begin
        merged = wdata_q;
        rd_ext = cur_word;
      end
    endcase
    mem_we = (state == WAIT) && (cnt == 4'd0) && wr_q;
  end

  // Storage array; not reset, written only on the WAIT to DONE edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      rdata    <= 32'h0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      misalign <= 1'b0;
      oob      <= 1'b0;
    end else begin
      ready    <= 1'b0;
      misalign <= 1'b0;
      oob      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= wr;
            size_q  <= size;
            busy    <= 1'b1;
            if (is_misaligned(size, addr[1:0]) || is_oob(addr[31:2])) begin
              state <= ERR;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            ready <= 1'b1;
            if (!wr_q) rdata <= rd_ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
          if (is_misaligned(size_q, addr_q[1:0])) misalign <= 1'b1;
          else                                    oob      <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder at the far end of the instruction/data address path of the multicycle CPU.
- Accepts one request per transaction from the control unit: address from the IorD address select, access size and write data.
- Performs the read or write after a programmable number of wait states, then pulses ready.
- Flags misaligned and out-of-range accesses so the control unit can raise an exception.
- Contains its own word-organised storage array.

Parameters:
- DEPTH, 256, number of 32-bit words in the storage array (power of two).
- WAIT_STATES, 2, extra cycles spent in WAIT before completion (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; sampled with req.
- size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- addr  input  32  byte address.
- wdata  input  32  write data; the low byte/half is used for byte/half writes.
- rdata  output  32  read data, zero-extended for byte/half.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever the state is not IDLE.
- misalign  output  1  one-cycle pulse with ready; access not size-aligned.
- oob  output  1  one-cycle pulse with ready; word index addr[31:2] >= DEPTH.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-high, port name reset.
- Reset values:
  - State = IDLE.
  - rdata = 0, ready = 0, busy = 0, misalign = 0, oob = 0.
  - The wait counter is cleared.
  - The storage array is not cleared by reset.
- Request capture: in IDLE, the edge that samples req=1 (the accept edge, E0) registers addr, wr, size and wdata. Inputs are don't-care after E0.
- States:
  - IDLE: waits for req.
    - Misaligned access (half with addr[0]=1, or word/reserved with addr[1:0]!=0) -> ERR.
    - Else oob -> ERR.
    - Else -> WAIT, with counter loaded to WAIT_STATES.
  - WAIT: if counter==0 -> DONE; else decrement the counter.
    - On the WAIT->DONE edge: a write updates the array; a read loads rdata.
  - DONE: ready=1 for this cycle -> IDLE.
  - ERR: ready=1 for this cycle, plus misalign or oob (misalign has priority; only one flag is set) -> IDLE. No array access; rdata holds its previous value.
- Latency: ready is high in the cycle following edge E(WAIT_STATES+1) after E0. Error responses are high in the cycle following E1.
- Byte lanes (little-endian within the word):
  - Byte lane k is bits [8k+7:8k], selected by addr[1:0].
  - Halfword lane is selected by addr[1]: 0 -> [15:0], 1 -> [31:16].
  - Writes merge into the addressed word; untouched lanes are preserved.
  - Reads of byte/half are zero-extended into rdata.
- Back-to-back: a req is sampled only in IDLE. The earliest next accept is the edge after the ready cycle. req held high continuously produces back-to-back transactions with one IDLE cycle between them.
- req high while not in IDLE is ignored; it is not queued.
- rdata is held stable from the ready cycle until the next completed read.
- Reset mid-operation:
  - The transaction is aborted and no pulse is issued.
  - A write not yet at the WAIT->DONE edge does not modify the array.
  - The array content at other addresses is unchanged.
- Address bits above the word index are not decoded beyond the oob check.

Test Plan:
- Word write then read, WAIT_STATES=2:
  - Write addr=0x10, wdata=0xDEADBEEF; req at E0 -> ready high in the cycle after E3, busy high E0..E3.
  - Read addr=0x10 -> rdata=0xDEADBEEF, misalign=0, oob=0.
- Byte/half merge:
  - Preload 0x11223344 at 0x20.
  - Byte write 0xAA to addr 0x22 -> word 0x11AA3344.
  - Half read at 0x22 -> rdata=0x000011AA.
  - Byte read at 0x23 -> 0x00000011.
- Misalignment:
  - Word read at 0x21 -> ready+misalign pulse in the cycle after E1, oob=0, rdata unchanged.
  - Half write at 0x23 -> misalign; the word at 0x20 is unchanged.
- Out of range, DEPTH=256:
  - Word read at 0x400 -> ready+oob after E1.
  - Word write at 0x3FC with 0x5 -> succeeds; read back 0x5.
- Request held during busy, WAIT_STATES=0:
  - req held high 6 cycles -> exactly 2 transactions complete (ready pulses 3 cycles apart); inputs changed mid-transaction do not affect the captured access.
- Reset mid-write:
  - Write 0xCAFEF00D to 0x30 (old value 0x0); assert reset after E1 with WAIT_STATES=3 -> all outputs 0, state IDLE.
  - Subsequent read of 0x30 returns 0x0.
